// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
//   Shared definitions for the data-memory responder:
//     - state_t      : responder FSM encoding (ST_IDLE / ST_WAIT / ST_RESP)
//     - WAIT_CNT_W   : width of the wait-state counter (supports 0..15 waits)
//     - STRB_*       : byte-strobe patterns for word and halfword stores
//     - misaligned() : alignment rule used when misalignment checking is built in
// -----------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int WAIT_CNT_W = 4;

  localparam logic [3:0] STRB_WORD    = 4'hF;
  localparam logic [3:0] STRB_HALF_LO = 4'h3;
  localparam logic [3:0] STRB_HALF_HI = 4'hC;

  // Loads are always word accesses. Stores are classified by strobe pattern;
  // single-byte and irregular strobes are never misaligned.
  function automatic logic misaligned(input logic       write,
                                      input logic [3:0] strb,
                                      input logic [1:0] lsb);
    logic bad;
    bad = 1'b0;
    if (!write) begin
      bad = (lsb != 2'b00);
    end else if (strb == STRB_WORD) begin
      bad = (lsb != 2'b00);
    end else if ((strb == STRB_HALF_LO) || (strb == STRB_HALF_HI)) begin
      bad = lsb[0];
    end
    return bad;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
//   2**ADDR_WIDTH x 32-bit data RAM built from four byte-wide banks so that each
//   lane maps onto a plain inferred block RAM with its own write enable.
//   Contents are not reset.
// Ports
//   clk    in   clock
//   we     in   write enable (qualified per lane by be)
//   be     in   4 byte enables, bit i controls wdata[8i+7:8i]
//   re     in   read enable; rdata only updates when re is high
//   addr   in   word index
//   wdata  in   write data
//   rdata  out  registered read data (holds between reads)
// -----------------------------------------------------------------------------
module dmem_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] bank [DEPTH];
    logic [7:0] lane_rdata_reg;

    always_ff @(posedge clk) begin
      if (we && be[gi]) begin
        bank[addr] <= wdata[8*gi +: 8];
      end
      if (re) begin
        lane_rdata_reg <= bank[addr];
      end
    end

    assign rdata[8*gi +: 8] = lane_rdata_reg;
  end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   MEM-stage data-memory responder. Accepts one load/store at a time over a
//   valid/ready handshake, waits WAIT_CYCLES cycles, commits the access to the
//   RAM on the edge entering RESP, then presents a registered response that is
//   held until the requester takes it.
//
//   Build option: define DMEM_MISALIGN_CHECK_EN to flag misaligned word and
//   halfword accesses as errors. Without it addr[1:0] is ignored.
//
// Parameters
//   ADDR_WIDTH   word-index width (depth = 2**ADDR_WIDTH words)
//   WAIT_CYCLES  wait states between accept and commit (0..15)
// Ports
//   clk        in   clock
//   rst        in   asynchronous reset, active-low
//   req_valid  in   request present
//   req_ready  out  request can be accepted (IDLE only)
//   req_write  in   1 = store, 0 = load
//   req_addr   in   byte address
//   req_wdata  in   store data
//   req_wstrb  in   store byte enables
//   rsp_valid  out  response present
//   rsp_ready  in   requester accepts response
//   rsp_rdata  out  load data (0 for stores and errors)
//   rsp_err    out  out-of-range (or misaligned, when enabled) access
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [WAIT_CNT_W-1:0] CNT_LAST =
    WAIT_CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  state_t                  state_reg, state_next;
  logic [WAIT_CNT_W-1:0]   wait_cnt_reg;

  logic                    write_reg;
  logic [31:0]             addr_reg;
  logic [31:0]             wdata_reg;
  logic [3:0]              wstrb_reg;

  logic                    acc_err_reg;   // committed access errored
  logic                    acc_rd_reg;    // committed access was a good load

  logic                    rsp_valid_reg;
  logic [31:0]             rsp_rdata_reg;
  logic                    rsp_err_reg;

  logic                    accept;
  logic                    commit;

  logic                    acc_write;
  logic [31:0]             acc_addr;
  logic [31:0]             acc_wdata;
  logic [3:0]              acc_wstrb;
  logic                    acc_oor;
  logic                    acc_mis;
  logic                    acc_err;

  logic [31:0]             ram_rdata;

  // Gating with rst keeps a request held across reset from being taken
  // (and, with zero wait states, from reaching the RAM) while reset is low.
  assign req_ready = rst && (state_reg == ST_IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) state_next = ST_RESP;
          else                  state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_reg == CNT_LAST) state_next = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_valid_reg && rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The RAM access happens on the edge that enters RESP. With zero wait
  // states that edge is the accept edge itself, so the live request fields
  // are used; otherwise the latched copy is.
  assign commit = (state_next == ST_RESP) && (state_reg != ST_RESP);

  always_comb begin
    acc_write = write_reg;
    acc_addr  = addr_reg;
    acc_wdata = wdata_reg;
    acc_wstrb = wstrb_reg;
    if (state_reg == ST_IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wstrb = req_wstrb;
    end
  end

  assign acc_oor = ((acc_addr >> (ADDR_WIDTH + 2)) != 32'd0);

`ifdef DMEM_MISALIGN_CHECK_EN
  assign acc_mis = misaligned(acc_write, acc_wstrb, acc_addr[1:0]);
`else
  assign acc_mis = 1'b0;
`endif

  assign acc_err = acc_oor || acc_mis;

  dmem_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (commit && acc_write && !acc_err),
    .be    (acc_wstrb),
    .re    (commit && !acc_write && !acc_err),
    .addr  (acc_addr[ADDR_WIDTH+1:2]),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      wait_cnt_reg  <= '0;
      write_reg     <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      acc_err_reg   <= 1'b0;
      acc_rd_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (accept) begin
        write_reg    <= req_write;
        addr_reg     <= req_addr;
        wdata_reg    <= req_wdata;
        wstrb_reg    <= req_wstrb;
        wait_cnt_reg <= '0;
      end else if (state_reg == ST_WAIT) begin
        wait_cnt_reg <= wait_cnt_reg + WAIT_CNT_W'(1);
      end

      if (commit) begin
        acc_err_reg <= acc_err;
        acc_rd_reg  <= !acc_write && !acc_err;
      end

      // First RESP cycle registers the RAM output into the response;
      // afterwards the response is frozen until the handshake.
      if (state_reg == ST_RESP) begin
        if (!rsp_valid_reg) begin
          rsp_valid_reg <= 1'b1;
          rsp_rdata_reg <= acc_rd_reg ? ram_rdata : 32'd0;
          rsp_err_reg   <= acc_err_reg;
        end else if (rsp_ready) begin
          rsp_valid_reg <= 1'b0;
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Directed self-checking bench for dmem_responder (ADDR_WIDTH=10,
//   WAIT_CYCLES=1). Inputs change and outputs are sampled 1 ns after the
//   rising clock edge.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_cmp;
  int n_bad;

  dmem_responder #(
    .ADDR_WIDTH  (10),
    .WAIT_CYCLES (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One request/response transaction with rsp_ready held high. Returns the
  // response and the number of edges from accept until rsp_valid was seen
  // (20 means it never came). After accept the req_* inputs are scrambled to
  // a store of 0 to word 0x10, which must have no effect.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic er,
                        output int lat);
    int g;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
    rsp_ready = 1'b1;
    g = 0;
    while (!req_ready && g < 20) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_wstrb = 4'hF;
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    rd = rsp_rdata; er = rsp_err;
    @(posedge clk); #1;
    $display("txn %s addr=%h wdata=%h wstrb=%h -> rdata=%h err=%b lat=%0d",
             w ? "ST" : "LD", a, d, s, rd, er, lat);
  endtask

  task automatic test_reset();
    rst = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0; req_wdata = 32'h1111_1111; req_wstrb = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rsp_rdata: got %h want 00000000", rsp_rdata); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    repeat (3) begin
      @(posedge clk); #1;
      n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        n_bad++; $display("FAIL reset_no_accept: rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready);
      end
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL store_latency: got %0d want 2", lat); end
    n_cmp++; if (er !== 1'b0 || rd !== 32'd0) begin n_bad++; $display("FAIL store_rsp: got err=%b rdata=%h want 0/00000000", er, rd); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL store_idle_after: got req_ready=%b want 1", req_ready); end
    do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL load_latency: got %0d want 2", lat); end
    n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL load_data: got %h want deadbeef", rd); end
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL load_err: got %b want 0", er); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h10, 32'h0000_00AA, 4'h1, rd, er, lat);
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL lane0_store_err: got %b want 0", er); end
    do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'hDEAD_BEAA) begin n_bad++; $display("FAIL lane0_load: got %h want deadbeaa", rd); end
    do_req(1'b1, 32'h10, 32'h5566_0000, 4'hC, rd, er, lat);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'h5566_BEAA) begin n_bad++; $display("FAIL halfhi_load: got %h want 5566beaa", rd); end
    do_req(1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, rd, er, lat);
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL nostrb_err: got %b want 0", er); end
    do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'h5566_BEAA) begin n_bad++; $display("FAIL nostrb_load: got %h want 5566beaa", rd); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h0, 32'h1234_5678, 4'hF, rd, er, lat);
    do_req(1'b1, 32'h1000, 32'hBADB_AD00, 4'hF, rd, er, lat);
    n_cmp++; if (er !== 1'b1 || rd !== 32'd0) begin n_bad++; $display("FAIL oor_store: got err=%b rdata=%h want 1/00000000", er, rd); end
    do_req(1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat);
    n_cmp++; if (er !== 1'b1 || rd !== 32'd0) begin n_bad++; $display("FAIL oor_load: got err=%b rdata=%h want 1/00000000", er, rd); end
    do_req(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'h1234_5678 || er !== 1'b0) begin n_bad++; $display("FAIL oor_no_write: got %h err=%b want 12345678/0", rd, er); end
    do_req(1'b1, 32'hFFC, 32'hCAFE_F00D, 4'hF, rd, er, lat);
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL top_word_store_err: got %b want 0", er); end
    do_req(1'b0, 32'hFFC, 32'h0, 4'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin n_bad++; $display("FAIL top_word_load: got %h err=%b want cafef00d/0", rd, er); end
  endtask

  task automatic test_backpressure();
    int g;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_wdata = 32'h0; req_wstrb = 4'h0;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    g = 0;
    while (!rsp_valid && g < 20) begin @(posedge clk); #1; g++; end
    n_cmp++; if (g !== 2) begin n_bad++; $display("FAIL bp_latency: got %0d want 2", g); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h5566_BEAA || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got valid=%b rdata=%h err=%b req_ready=%b want 1/5566beaa/0/0",
                 k, rsp_valid, rsp_rdata, rsp_err, req_ready);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_release: got valid=%b req_ready=%b want 0/1", rsp_valid, req_ready);
    end
    $display("txn LD addr=00000010 backpressure 5 cycles");
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, 32'h12, 32'h0, 4'h0, rd, er, lat);
`ifdef DMEM_MISALIGN_CHECK_EN
    n_cmp++; if (er !== 1'b1 || rd !== 32'd0) begin n_bad++; $display("FAIL misalign_load: got err=%b rdata=%h want 1/00000000", er, rd); end
`else
    n_cmp++; if (er !== 1'b0 || rd !== 32'h5566_BEAA) begin n_bad++; $display("FAIL misalign_load: got err=%b rdata=%h want 0/5566beaa", er, rd); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h14, 32'h0BAD_F00D, 4'hF, rd, er, lat);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b want 1", req_ready); end
    do_req(1'b0, 32'h14, 32'h0, 4'h0, rd, er, lat);
    n_cmp++; if (lat !== 2 || rd !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL b2b_load: got lat=%0d rdata=%h want 2/0badf00d", lat, rd); end
    do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'h5566_BEAA) begin n_bad++; $display("FAIL b2b_latched_inputs: got %h want 5566beaa", rd); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_out_of_range();
    test_backpressure();
    test_misalign();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
